cic_comb_decim: RTL and testbench

Decimating comb stage that sits directly downstream of the running accumulator (integrator). It samples the accumulator's registered output on each enabled cycle and, every R enabled samples, emits the modulo-2^W difference between the current sample and the one taken R samples earlier. Together with the accumulator this forms a single-stage integrate-and-dump (CIC, N=1, M=1) decimator. The result is offered on a valid/ready output with overrun detection.

---
 rtl/cic_comb_decim_if.sv | 14 +
 rtl/cic_comb_decim.sv | 87 ++++++++
 tb/tb_cic_comb_decim.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_comb_decim_if.sv
// Decimated result channel of the comb stage: dout/dout_valid offered by the
// comb, dout_ready returned by the consumer.
interface cic_comb_decim_if #(
  parameter int W = 16
);
  // A result transfers on any rising edge where dout_valid and dout_ready are
  // both high; while dout_valid=1 and dout_ready=0 the source holds dout stable.
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/cic_comb_decim.sv
// Decimating comb (N=1, M=1) behind an integrator: every R enabled samples it
// emits acc minus the acc seen at the previous strobe, with sticky overrun flag.
module cic_comb_decim #(
  parameter int W  = 16,
  parameter int R  = 4,
  parameter int CW = $clog2(R)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [W-1:0]            acc,
  cic_comb_decim_if.master        out,
  output logic                    ovf
);

  generate
    if (R < 2) begin : g_bad_r
      $error("cic_comb_decim: R must be at least 2");
    end
  endgenerate

  // Reset asserts immediately but releases two edges later, in step with clk.
  logic [1:0] rst_sync;
  logic       rst_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_hold = rst_sync[1];

  logic [CW-1:0] cnt;
  logic [W-1:0]  prev;
  logic [W-1:0]  dout_q;
  logic          valid_q;
  logic          sample;
  logic          strobe;
  logic [W-1:0]  res;

  assign sample = en & ~clr;
  assign strobe = sample && (cnt == CW'(R - 1));
  assign res    = acc - prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      prev    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf     <= 1'b0;
    end else if (rst_hold || clr) begin
      cnt     <= '0;
      prev    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (strobe) begin
        cnt  <= '0;
        prev <= acc;
      end else if (sample) begin
        cnt <= cnt + 1'b1;
      end

      // A dropped result still advances prev so the next window stays correct.
      if (strobe) begin
        if (!valid_q || out.dout_ready) begin
          dout_q  <= res;
          valid_q <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (valid_q && out.dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out.dout       = dout_q;
  assign out.dout_valid = valid_q;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Bench for cic_comb_decim (W=16, R=4): directed scenarios plus random traffic,
// checked against a sample-counting reference model with a one-deep result queue.
module tb_cic_comb_decim;
  localparam int W = 16;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] acc = '0;
  logic         ovf;

  cic_comb_decim_if #(.W(W)) ifc ();

  cic_comb_decim #(.W(W), .R(R)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .acc (acc),
    .out (ifc),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: total samples since clear, acc at last strobe, pending results.
  int unsigned  n_samp = 0;
  logic [W-1:0] m_ref  = '0;
  logic [W-1:0] m_dout = '0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic model_clear();
    n_samp = 0;
    m_ref  = '0;
    m_dout = '0;
    m_ovf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] r;
    if (clr) begin
      model_clear();
    end else begin
      if (ifc.dout_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (en) begin
        n_samp++;
        if (n_samp % R == 0) begin
          r     = acc - m_ref;
          m_ref = acc;
          if (exp_q.size() == 0) begin
            exp_q.push_back(r);
            m_dout = r;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; ifc.dout_ready = 1'b0; acc = '0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifc.dout_valid); end
    checks++; if (ifc.dout !== 16'h0) begin errors++; $display("FAIL reset_dout got %h exp 0000", ifc.dout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst = 1'b0;
    model_clear();
    repeat (3) tick();
    checks++; if (ifc.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b exp 0", ifc.dout_valid); end
  endtask

  task automatic test_ramp();
    int first_seen = 0;
    do_clr();
    ifc.dout_ready = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      acc = W'(10 * i);
      tick();
      checks++; if (ifc.dout_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL ramp_valid cyc %0d got %b exp %b", i, ifc.dout_valid, exp_q.size() != 0); end
      checks++; if (ifc.dout !== m_dout) begin errors++; $display("FAIL ramp_dout cyc %0d got %h exp %h", i, ifc.dout, m_dout); end
      if (i == 4) begin
        checks++; if (ifc.dout_valid !== 1'b1 || ifc.dout !== 16'd40) begin errors++; $display("FAIL ramp_first got v=%b d=%0d exp v=1 d=40", ifc.dout_valid, ifc.dout); end
        first_seen = 1;
      end
      if (ifc.dout_valid === 1'b1) begin
        checks++; if (ifc.dout !== 16'd40) begin errors++; $display("FAIL ramp_const got %0d exp 40", ifc.dout); end
      end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ramp_ovf got %b exp 0", ovf); end
    checks++; if (first_seen != 1) begin errors++; $display("FAIL ramp_first_seen got %0d exp 1", first_seen); end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    do_clr();
    ifc.dout_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = (i == 3) ? 16'hFFF0 : (i == 7) ? 16'h0010 : W'($urandom);
      tick();
    end
    en = 1'b0;
    checks++; if (ifc.dout !== 16'h0020 || ifc.dout_valid !== 1'b1) begin errors++; $display("FAIL wrap_dout got v=%b d=%h exp v=1 d=0020", ifc.dout_valid, ifc.dout); end
    checks++; if (ifc.dout !== m_dout) begin errors++; $display("FAIL wrap_model got %h exp %h", ifc.dout, m_dout); end
  endtask

  task automatic test_backpressure();
    do_clr();
    ifc.dout_ready = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      acc = W'(10 * i);
      tick();
      checks++; if (ifc.dout !== m_dout || ifc.dout_valid !== (exp_q.size() != 0) || ovf !== m_ovf) begin
        errors++; $display("FAIL bp_track cyc %0d got d=%h v=%b o=%b exp d=%h v=%b o=%b", i, ifc.dout, ifc.dout_valid, ovf, m_dout, exp_q.size() != 0, m_ovf);
      end
    end
    checks++; if (ifc.dout !== 16'd40 || ifc.dout_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got v=%b d=%0d exp v=1 d=40", ifc.dout_valid, ifc.dout); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b exp 1", ovf); end
    en = 1'b0;
    ifc.dout_ready = 1'b1;
    tick();
    ifc.dout_ready = 1'b0;
    checks++; if (ifc.dout_valid !== 1'b0) begin errors++; $display("FAIL bp_consume got %b exp 0", ifc.dout_valid); end
    en = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      acc = W'(10 * i);
      tick();
    end
    en = 1'b0;
    checks++; if (ifc.dout !== 16'd40 || ifc.dout_valid !== 1'b1) begin errors++; $display("FAIL bp_after got v=%b d=%0d exp v=1 d=40", ifc.dout_valid, ifc.dout); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b exp 1", ovf); end
    do_clr();
    checks++; if (ovf !== 1'b0 || ifc.dout_valid !== 1'b0 || ifc.dout !== 16'h0) begin errors++; $display("FAIL bp_clr got o=%b v=%b d=%h exp 0 0 0000", ovf, ifc.dout_valid, ifc.dout); end
  endtask

  task automatic test_enable_gaps();
    logic [W-1:0] a = '0;
    int last = -1;
    int seen = 0;
    do_clr();
    ifc.dout_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      en = (i % 2 == 0);
      if (en) a = a + 16'd5;
      acc = a;
      tick();
      if (ifc.dout_valid === 1'b1) begin
        seen++;
        checks++; if (ifc.dout !== 16'd20) begin errors++; $display("FAIL gap_dout got %0d exp 20", ifc.dout); end
        if (last >= 0) begin
          checks++; if (i - last != 8) begin errors++; $display("FAIL gap_period got %0d exp 8", i - last); end
        end
        last = i;
      end
    end
    en = 1'b0;
    checks++; if (seen != 5) begin errors++; $display("FAIL gap_count got %0d exp 5", seen); end
  endtask

  task automatic test_clr_mid_window();
    do_clr();
    ifc.dout_ready = 1'b1;
    en = 1'b1;
    acc = 16'd3; tick();
    acc = 16'd6; tick();
    clr = 1'b1; acc = 16'd999; tick(); clr = 1'b0;
    checks++; if (ifc.dout_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b exp 0", ifc.dout_valid); end
    for (int i = 1; i <= 4; i++) begin
      acc = W'(7 * i);
      tick();
      if (i < 4) begin
        checks++; if (ifc.dout_valid !== 1'b0) begin errors++; $display("FAIL clr_early sample %0d got %b exp 0", i, ifc.dout_valid); end
      end
    end
    en = 1'b0;
    checks++; if (ifc.dout_valid !== 1'b1 || ifc.dout !== 16'd28) begin errors++; $display("FAIL clr_result got v=%b d=%0d exp v=1 d=28", ifc.dout_valid, ifc.dout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      ifc.dout_ready = $urandom_range(0, 1);
      clr = ($urandom_range(0, 63) == 0);
      acc = W'($urandom);
      tick();
      checks++; if (ifc.dout_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, ifc.dout_valid, exp_q.size() != 0); end
      checks++; if (ifc.dout !== m_dout) begin errors++; $display("FAIL rand_dout cyc %0d got %h exp %h", i, ifc.dout, m_dout); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d got %b exp %b", i, ovf, m_ovf); end
    end
    clr = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] last_acc = '0;
    do_clr();
    ifc.dout_ready = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      acc = W'(100 * i);
      tick();
    end
    en = 1'b0;
    checks++; if (ifc.dout_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", ifc.dout_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ifc.dout_valid !== 1'b0 || ifc.dout !== 16'h0) begin errors++; $display("FAIL arst_immediate got v=%b d=%h exp v=0 d=0000", ifc.dout_valid, ifc.dout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf got %b exp 0", ovf); end
    #1 rst = 1'b0;
    model_clear();
    repeat (3) tick();
    en = 1'b1;
    for (int i = 0; i < R; i++) begin
      acc = W'($urandom);
      last_acc = acc;
      tick();
    end
    en = 1'b0;
    checks++; if (ifc.dout_valid !== 1'b1 || ifc.dout !== last_acc) begin errors++; $display("FAIL arst_first got v=%b d=%h exp v=1 d=%h", ifc.dout_valid, ifc.dout, last_acc); end
  endtask

  initial begin
    ifc.dout_ready = 1'b0;
    test_reset();
    test_ramp();
    test_wrap();
    test_backpressure();
    test_enable_gaps();
    test_clr_mid_window();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
